// File: rtl/tessia_pkg.sv
// Shared Tessia execute-pipeline types: opcodes, ALU control codes and the
// decoded instruction bundle handed from decode to the execute-stage ALU.
package tessia_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_OR   = 4'h3,
    OP_MOD  = 4'h4,
    OP_AND  = 4'h5,
    OP_MOVI = 4'h6,
    OP_DIV  = 4'h7,
    OP_ADDI = 4'h8,
    OP_SUBI = 4'h9,
    OP_CMP  = 4'hA,
    OP_NOP  = 4'hB
  } opcode_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MOD = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_MOV = 4'b0110;
  localparam logic [3:0] ALU_DIV = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1000;

  // imm holds the raw 8-bit instruction field; widening to the ALU operand
  // width happens at the decoder output.
  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       use_imm;
    logic       reg_we;
    logic       flag_we;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
    logic       illegal;
  } dec_bundle_t;

  localparam int DEC_W = $bits(dec_bundle_t);

  function automatic dec_bundle_t decode_instr(input logic [23:0] instr);
    dec_bundle_t b;
    opcode_t     op;
    op        = opcode_t'(instr[23:20]);
    b.alu_ctrl = ALU_NOP;
    b.use_imm  = 1'b0;
    b.reg_we   = 1'b0;
    b.flag_we  = 1'b0;
    b.rd       = instr[19:16];
    b.rs1      = instr[15:12];
    b.rs2      = instr[11:8];
    b.imm      = instr[7:0];
    b.illegal  = 1'b0;
    case (op)
      OP_ADD:  begin b.alu_ctrl = ALU_ADD; b.reg_we = 1'b1; b.flag_we = 1'b1; end
      OP_SUB:  begin b.alu_ctrl = ALU_SUB; b.reg_we = 1'b1; b.flag_we = 1'b1; end
      OP_MUL:  begin b.alu_ctrl = ALU_MUL; b.reg_we = 1'b1; b.flag_we = 1'b1; end
      OP_OR:   begin b.alu_ctrl = ALU_OR;  b.reg_we = 1'b1; b.flag_we = 1'b1; end
      OP_MOD:  begin b.alu_ctrl = ALU_MOD; b.reg_we = 1'b1; b.flag_we = 1'b1; end
      OP_AND:  begin b.alu_ctrl = ALU_AND; b.reg_we = 1'b1; b.flag_we = 1'b1; end
      OP_MOVI: begin b.alu_ctrl = ALU_MOV; b.use_imm = 1'b1; b.reg_we = 1'b1; end
      OP_DIV:  begin b.alu_ctrl = ALU_DIV; b.reg_we = 1'b1; b.flag_we = 1'b1; end
      OP_ADDI: begin
        b.alu_ctrl = ALU_ADD; b.use_imm = 1'b1; b.reg_we = 1'b1; b.flag_we = 1'b1;
      end
      OP_SUBI: begin
        b.alu_ctrl = ALU_SUB; b.use_imm = 1'b1; b.reg_we = 1'b1; b.flag_we = 1'b1;
      end
      // Compare only updates flags; the difference is discarded.
      OP_CMP:  begin b.alu_ctrl = ALU_SUB; b.flag_we = 1'b1; end
      OP_NOP:  b.alu_ctrl = ALU_NOP;
      default: begin b.alu_ctrl = ALU_NOP; b.illegal = 1'b1; end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: a main register drives the outputs and a
// skid register absorbs one word when the sink stalls. in_ready is registered.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         acc, xfer;

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;

  assign acc  = in_valid && !skid_vld_q;
  assign xfer = main_vld_q && out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (xfer) begin
      // A full skid blocks acceptance, so it simply drains into main here.
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        main_d     = in_data;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (acc) begin
      if (!main_vld_q) begin
        main_d     = in_data;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_data;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Tessia decode stage: combinational opcode decode feeding a skid buffer that
// holds the decoded bundle presented to the execute-stage ALU.
module alu_op_decoder
  import tessia_pkg::*;
#(
  parameter int INSTR_W = 24,
  parameter int N       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_alu_ctrl,
  output logic               out_use_imm,
  output logic               out_reg_we,
  output logic               out_flag_we,
  output logic [3:0]         out_rd,
  output logic [3:0]         out_rs1,
  output logic [3:0]         out_rs2,
  output logic [N-1:0]       out_imm,
  output logic               out_illegal
);

  dec_bundle_t      dec_bundle;
  dec_bundle_t      out_bundle;
  logic [DEC_W-1:0] out_payload;

  assign dec_bundle = decode_instr(in_instr);

  skid_buffer #(.W(DEC_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_bundle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_bundle   = dec_bundle_t'(out_payload);
  assign out_alu_ctrl = out_bundle.alu_ctrl;
  assign out_use_imm  = out_bundle.use_imm;
  assign out_reg_we   = out_bundle.reg_we;
  assign out_flag_we  = out_bundle.flag_we;
  assign out_rd       = out_bundle.rd;
  assign out_rs1      = out_bundle.rs1;
  assign out_rs2      = out_bundle.rs2;
  assign out_illegal  = out_bundle.illegal;

  // Zero-extend the 8-bit immediate to the ALU operand width.
  always_comb begin
    out_imm      = '0;
    out_imm[7:0] = out_bundle.imm;
  end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed and randomized bench for alu_op_decoder with an independent
// opcode-table model and a FIFO scoreboard for the handshake.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [23:0] in_instr;
  logic [3:0]  out_alu_ctrl, out_rd, out_rs1, out_rs2;
  logic        out_use_imm, out_reg_we, out_flag_we, out_illegal;
  logic [7:0]  out_imm;

  int n_assert = 0;
  int n_fail   = 0;

  alu_op_decoder #(.INSTR_W(24), .N(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_use_imm(out_use_imm),
    .out_reg_we(out_reg_we), .out_flag_we(out_flag_we),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ctrl[3:0], use_imm, reg_we, flag_we, illegal} straight from the opcode table
  function automatic logic [7:0] model(input logic [23:0] instr);
    case (instr[23:20])
      4'h0: return 8'b0000_0110;
      4'h1: return 8'b0001_0110;
      4'h2: return 8'b0010_0110;
      4'h3: return 8'b0011_0110;
      4'h4: return 8'b0100_0110;
      4'h5: return 8'b0101_0110;
      4'h6: return 8'b0110_1100;
      4'h7: return 8'b0111_0110;
      4'h8: return 8'b0000_1110;
      4'h9: return 8'b0001_1110;
      4'hA: return 8'b0001_0010;
      4'hB: return 8'b1000_0000;
      default: return 8'b1000_0001;
    endcase
  endfunction

  task automatic chk_out(input string tag, input logic [23:0] instr);
    logic [7:0] e;
    e = model(instr);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".ctrl"}, out_alu_ctrl, e[7:4]);
    chk({tag, ".use_imm"}, out_use_imm, e[3]);
    chk({tag, ".reg_we"}, out_reg_we, e[2]);
    chk({tag, ".flag_we"}, out_flag_we, e[1]);
    chk({tag, ".illegal"}, out_illegal, e[0]);
    chk({tag, ".rd"}, out_rd, instr[19:16]);
    chk({tag, ".rs1"}, out_rs1, instr[15:12]);
    chk({tag, ".rs2"}, out_rs2, instr[11:8]);
    chk({tag, ".imm"}, out_imm, instr[7:0]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, out_valid, 1'b0);
    chk({tag, ".fields"},
        {out_alu_ctrl, out_use_imm, out_reg_we, out_flag_we, out_rd, out_rs1,
         out_rs2, out_imm, out_illegal}, 32'h0);
    chk({tag, ".in_ready"}, in_ready, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [23:0] I_ADD  = 24'h012305;
  localparam logic [23:0] I_SUB  = 24'h14560A;
  localparam logic [23:0] I_MUL  = 24'h2789C3;
  localparam logic [23:0] I_MOVI = 24'h60007F;
  localparam logic [23:0] I_CMP  = 24'hA01200;
  localparam logic [23:0] I_ILL  = 24'hE3456F;
  localparam logic [23:0] I_AND  = 24'h5123AA;
  localparam logic [23:0] I_OR   = 24'h3ABC11;

  logic [23:0] q[$];
  logic [31:0] prev_fields;
  logic        prev_stall;
  int          words, cycles;
  logic        acc, xfer;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;

    // Single ADD, streaming sink
    out_ready = 1'b1; in_valid = 1'b1; in_instr = I_ADD;
    step();
    in_valid = 1'b0;
    chk_out("add", I_ADD);
    step();
    chk("add_drain.valid", out_valid, 1'b0);

    // MOVI, CMP, illegal back to back
    in_valid = 1'b1; in_instr = I_MOVI;
    step(); chk_out("movi", I_MOVI);
    in_instr = I_CMP;
    step(); chk_out("cmp", I_CMP);
    in_instr = I_ILL;
    step(); chk_out("ill", I_ILL);
    in_valid = 1'b0;
    step(); chk("seq_drain.valid", out_valid, 1'b0);

    // Stall: ADD to main, SUB to skid, MUL held off
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADD;
    step(); chk("stall1.in_ready", in_ready, 1'b1); chk_out("stall1", I_ADD);
    in_instr = I_SUB;
    step(); chk("stall2.in_ready", in_ready, 1'b0); chk_out("stall2", I_ADD);
    in_instr = I_MUL;
    step(); chk("stall3.in_ready", in_ready, 1'b0); chk_out("stall3", I_ADD);
    out_ready = 1'b1;
    step(); chk_out("rel_sub", I_SUB); chk("rel_sub.in_ready", in_ready, 1'b1);
    step(); chk_out("rel_mul", I_MUL);
    in_valid = 1'b0;
    step(); chk("rel_drain.valid", out_valid, 1'b0);

    // Flush with both entries full and a word on the input
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADD;
    step(); in_instr = I_SUB;
    step(); chk("fl_full.in_ready", in_ready, 1'b0);
    flush = 1'b1; in_instr = I_MUL;
    step();
    chk("flush.valid", out_valid, 1'b0); chk("flush.in_ready", in_ready, 1'b1);
    in_instr = I_OR;
    step(); chk("flush2.valid", out_valid, 1'b0);
    flush = 1'b0; out_ready = 1'b1; in_instr = I_AND;
    step(); chk_out("post_flush", I_AND);
    in_valid = 1'b0;
    step(); chk("post_flush_drain.valid", out_valid, 1'b0);

    // Reset mid-stream with buffered words and a word on the input
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_MOVI;
    step(); in_instr = I_SUB;
    step();
    rst = 1'b1; in_instr = I_MUL;
    step(); chk_zero("mid_rst");
    rst = 1'b0; in_valid = 1'b0;
    step(); chk_zero("mid_rst_after");

    // Randomized valid/ready against a FIFO scoreboard
    words = 0; cycles = 0; prev_stall = 1'b0; prev_fields = '0;
    while (words < 10000 && cycles < 60000) begin
      chk("rnd.in_ready", in_ready, q.size() < 2);
      chk("rnd.valid", out_valid, q.size() > 0);
      if (q.size() > 0) chk_out("rnd", q[0]);
      if (prev_stall)
        chk("rnd.stable", {out_alu_ctrl, out_use_imm, out_reg_we, out_flag_we,
                           out_rd, out_rs1, out_rs2, out_imm, out_illegal}, prev_fields);
      prev_fields = {out_alu_ctrl, out_use_imm, out_reg_we, out_flag_we,
                     out_rd, out_rs1, out_rs2, out_imm, out_illegal};
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_instr  = 24'($urandom);
      acc  = in_valid && (q.size() < 2);
      xfer = (q.size() > 0) && out_ready;
      prev_stall = (q.size() > 0) && !out_ready;
      step();
      cycles++;
      if (xfer) void'(q.pop_front());
      if (acc) begin
        q.push_back(in_instr);
        words++;
      end
    end
    chk("rnd.words_done", words, 10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
